// File: rtl/cond_branch_seq.sv
// ---------------------------------------------------------------------------
// cond_branch_seq
//
// Program-counter sequencer on the consuming side of the condition
// interface. It keeps an 8-bit signed flags value written by the ALU and
// evaluates 3-bit branch condition codes against it. The PC either advances
// by STEP or loads a branch target. Every taken branch is followed by a
// fixed pipeline-flush bubble of FLUSH_CYCLES cycles.
//
// Condition codes on effective flags F (signed):
//   0 never   1 F==0   2 F<0    3 F<=0
//   4 always  5 F!=0   6 F>=0   7 F>0
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          asynchronous reset, active low
//   en_i            advance enable for the PC
//   flag_valid_i    write flag_value_i into the flags register
//   flag_value_i    ALU result, two's-complement signed
//   br_valid_i      branch request present
//   br_cond_i       condition code, only bits [2:0] are used
//   br_target_i     branch destination address
//   br_ready_o      branch request can be accepted (combinational)
//   pc_o            current fetch address
//   taken_o         registered one-cycle pulse per accepted taken branch
//   busy_o          high while flushing after a taken branch
//
// Optional feature (macro COND_BRANCH_STATS_EN):
//   taken_count_o     saturating count of accepted taken branches
//   nottaken_count_o  saturating count of accepted not-taken branches
// ---------------------------------------------------------------------------
module cond_branch_seq #(
  parameter int PC_WIDTH     = 8,
  parameter int STEP         = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                flag_valid_i,
  input  logic [7:0]          flag_value_i,
  input  logic                br_valid_i,
  input  logic [7:0]          br_cond_i,
  input  logic [PC_WIDTH-1:0] br_target_i,
  output logic                br_ready_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                taken_o,
  output logic                busy_o
`ifdef COND_BRANCH_STATS_EN
  ,
  output logic [15:0]         taken_count_o,
  output logic [15:0]         nottaken_count_o
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(STEP);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    flushCnt_q, flushCnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          flags_q;
  logic                taken_q;

  logic signed [7:0]   effFlags;
  logic                condTrue;
  logic                accept;
  logic                takeBranch;
  logic                unusedCondBits;

  // Condition code bits [7:3] carry no meaning here.
  assign unusedCondBits = ^br_cond_i[7:3];

  // A flags write in the same cycle is forwarded to the branch decision.
  assign effFlags = flag_valid_i ? flag_value_i : flags_q;

  always_comb begin
    condTrue = 1'b0;
    unique case (br_cond_i[2:0])
      3'd0: condTrue = 1'b0;
      3'd1: condTrue = (effFlags == 8'sd0);
      3'd2: condTrue = (effFlags <  8'sd0);
      3'd3: condTrue = (effFlags <= 8'sd0);
      3'd4: condTrue = 1'b1;
      3'd5: condTrue = (effFlags != 8'sd0);
      3'd6: condTrue = (effFlags >= 8'sd0);
      3'd7: condTrue = (effFlags >  8'sd0);
      default: condTrue = 1'b0;
    endcase
  end

  assign accept     = br_valid_i & br_ready_o;
  assign takeBranch = accept & condTrue;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  // Next-state logic. With FLUSH_CYCLES == 0 the FLUSH state is never entered.
  always_comb begin
    state_d    = state_q;
    flushCnt_d = flushCnt_q;
    pc_d       = pc_q;
    unique case (state_q)
      RUN: begin
        if (takeBranch) begin
          pc_d = br_target_i;
          if (FLUSH_CYCLES > 0) begin
            state_d    = FLUSH;
            flushCnt_d = CNT_INIT;
          end
        end else if (en_i) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      FLUSH: begin
        if (flushCnt_q == '0) begin
          state_d = RUN;
        end else begin
          flushCnt_d = flushCnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output logic.
  always_comb begin
    br_ready_o = (state_q == RUN);
    busy_o     = (state_q == FLUSH);
  end

  // Datapath registers: pc, flags (written in any state) and taken pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      flags_q <= '0;
      taken_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= takeBranch;
      if (flag_valid_i) begin
        flags_q <= flag_value_i;
      end
    end
  end

  assign pc_o    = pc_q;
  assign taken_o = taken_q;

`ifdef COND_BRANCH_STATS_EN
  logic [15:0] takenCnt_q;
  logic [15:0] notTakenCnt_q;

  // Saturating branch statistics.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      takenCnt_q    <= '0;
      notTakenCnt_q <= '0;
    end else begin
      if (takeBranch && takenCnt_q != 16'hFFFF) begin
        takenCnt_q <= takenCnt_q + 16'd1;
      end
      if (accept && !condTrue && notTakenCnt_q != 16'hFFFF) begin
        notTakenCnt_q <= notTakenCnt_q + 16'd1;
      end
    end
  end

  assign taken_count_o    = takenCnt_q;
  assign nottaken_count_o = notTakenCnt_q;
`endif

endmodule

// File: tb/tb_cond_branch_seq.sv
// ---------------------------------------------------------------------------
// tb_cond_branch_seq
//
// Directed testbench for cond_branch_seq with default parameters
// (PC_WIDTH=8, STEP=4, FLUSH_CYCLES=2). Inputs change 1 ns after the rising
// edge and outputs are sampled at that same point, well away from the edge.
// ---------------------------------------------------------------------------
module tb_cond_branch_seq;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic       flag_valid_i;
  logic [7:0] flag_value_i;
  logic       br_valid_i;
  logic [7:0] br_cond_i;
  logic [7:0] br_target_i;
  logic       br_ready_o;
  logic [7:0] pc_o;
  logic       taken_o;
  logic       busy_o;
`ifdef COND_BRANCH_STATS_EN
  logic [15:0] taken_count_o;
  logic [15:0] nottaken_count_o;
`endif

  int checkCount = 0;
  int passCount  = 0;

  cond_branch_seq dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .flag_valid_i (flag_valid_i),
    .flag_value_i (flag_value_i),
    .br_valid_i   (br_valid_i),
    .br_cond_i    (br_cond_i),
    .br_target_i  (br_target_i),
    .br_ready_o   (br_ready_o),
    .pc_o         (pc_o),
    .taken_o      (taken_o),
    .busy_o       (busy_o)
`ifdef COND_BRANCH_STATS_EN
    ,
    .taken_count_o    (taken_count_o),
    .nottaken_count_o (nottaken_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; en_i = 1'b0; flag_valid_i = 1'b0; flag_value_i = 8'h00;
    br_valid_i = 1'b0; br_cond_i = 8'h00; br_target_i = 8'h00;
    tick();
    tick();
    checkCount++;
    if ({pc_o, taken_o, busy_o, br_ready_o} !== {8'h00, 3'b001})
      $display("[TB] FAIL reset_outputs: pc=%0h taken=%0b busy=%0b ready=%0b expected pc=0 taken=0 busy=0 ready=1",
               pc_o, taken_o, busy_o, br_ready_o);
    else passCount++;
    rst_ni = 1'b1;
  endtask

  task automatic test_increment();
    logic [7:0] expPc;
    expPc = 8'h00;
    en_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expPc = expPc + 8'd4;
      checkCount++;
      if (pc_o !== expPc || taken_o !== 1'b0 || br_ready_o !== 1'b1)
        $display("[TB] FAIL increment_%0d: pc=%0d taken=%0b ready=%0b expected pc=%0d taken=0 ready=1",
                 i, pc_o, taken_o, br_ready_o, expPc);
      else passCount++;
    end
  endtask

  task automatic test_wrap();
    // pc is 20 here; 58 more steps reach 252.
    en_i = 1'b1;
    for (int i = 0; i < 58; i++) tick();
    checkCount++;
    if (pc_o !== 8'd252)
      $display("[TB] FAIL wrap_pre: pc=%0d expected 252", pc_o);
    else passCount++;
    tick();
    checkCount++;
    if (pc_o !== 8'd0 || busy_o !== 1'b0)
      $display("[TB] FAIL wrap_post: pc=%0d busy=%0b expected pc=0 busy=0", pc_o, busy_o);
    else passCount++;
  endtask

  task automatic test_forward_branch();
    // pc is 0; flags written to 0 and used by cond 1 in the same cycle.
    en_i = 1'b1;
    flag_valid_i = 1'b1; flag_value_i = 8'h00;
    br_valid_i = 1'b1; br_cond_i = 8'h01; br_target_i = 8'h40;
    tick();
    flag_valid_i = 1'b0; br_valid_i = 1'b0;
    checkCount++;
    if ({pc_o, taken_o, busy_o, br_ready_o} !== {8'h40, 3'b110})
      $display("[TB] FAIL fwd_taken: pc=%0h taken=%0b busy=%0b ready=%0b expected pc=40 taken=1 busy=1 ready=0",
               pc_o, taken_o, busy_o, br_ready_o);
    else passCount++;
    tick();
    checkCount++;
    if ({pc_o, taken_o, busy_o, br_ready_o} !== {8'h40, 3'b010})
      $display("[TB] FAIL fwd_flush2: pc=%0h taken=%0b busy=%0b ready=%0b expected pc=40 taken=0 busy=1 ready=0",
               pc_o, taken_o, busy_o, br_ready_o);
    else passCount++;
    tick();
    checkCount++;
    if ({pc_o, taken_o, busy_o, br_ready_o} !== {8'h40, 3'b001})
      $display("[TB] FAIL fwd_run: pc=%0h taken=%0b busy=%0b ready=%0b expected pc=40 taken=0 busy=0 ready=1",
               pc_o, taken_o, busy_o, br_ready_o);
    else passCount++;
    tick();
    checkCount++;
    if (pc_o !== 8'h44)
      $display("[TB] FAIL fwd_advance: pc=%0h expected 44", pc_o);
    else passCount++;
  endtask

  task automatic test_cond_codes();
    logic [7:0] codes [9];
    logic       expTaken [9];
    logic [7:0] expPc;
    codes    = '{8'h02, 8'h03, 8'h05, 8'h01, 8'h06, 8'h07, 8'hF8, 8'h00, 8'h04};
    expTaken = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
    // Write flags = -2 with the PC frozen.
    en_i = 1'b0; flag_valid_i = 1'b1; flag_value_i = 8'hFE;
    tick();
    flag_valid_i = 1'b0;
    expPc = 8'h44;
    for (int i = 0; i < 9; i++) begin
      en_i = 1'b1; br_valid_i = 1'b1; br_cond_i = codes[i]; br_target_i = 8'h80;
      tick();
      br_valid_i = 1'b0; en_i = 1'b0;
      expPc = expTaken[i] ? 8'h80 : expPc + 8'd4;
      checkCount++;
      if (pc_o !== expPc || taken_o !== expTaken[i])
        $display("[TB] FAIL cond_%0h: pc=%0h taken=%0b expected pc=%0h taken=%0b",
                 codes[i], pc_o, taken_o, expPc, expTaken[i]);
      else passCount++;
      if (expTaken[i]) begin
        tick();
        tick();
      end
    end
    checkCount++;
    if (busy_o !== 1'b0 || pc_o !== expPc)
      $display("[TB] FAIL cond_end: pc=%0h busy=%0b expected pc=%0h busy=0", pc_o, busy_o, expPc);
    else passCount++;
  endtask

  task automatic test_flush_ignore();
    int pulses;
    pulses = 0;
    en_i = 1'b0; br_valid_i = 1'b1; br_cond_i = 8'h04; br_target_i = 8'h10;
    tick();
    br_target_i = 8'h20;
    checkCount++;
    if (pc_o !== 8'h10 || taken_o !== 1'b1)
      $display("[TB] FAIL hold_first: pc=%0h taken=%0b expected pc=10 taken=1", pc_o, taken_o);
    else passCount++;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (taken_o === 1'b1) pulses++;
      checkCount++;
      if (pc_o !== 8'h10)
        $display("[TB] FAIL hold_flush_%0d: pc=%0h expected 10", i, pc_o);
      else passCount++;
    end
    checkCount++;
    if (br_ready_o !== 1'b1 || busy_o !== 1'b0)
      $display("[TB] FAIL hold_run: ready=%0b busy=%0b expected ready=1 busy=0", br_ready_o, busy_o);
    else passCount++;
    tick();
    br_valid_i = 1'b0;
    if (taken_o === 1'b1) pulses++;
    checkCount++;
    if (pc_o !== 8'h20)
      $display("[TB] FAIL hold_accept: pc=%0h expected 20", pc_o);
    else passCount++;
    tick();
    if (taken_o === 1'b1) pulses++;
    checkCount++;
    if (pulses !== 1)
      $display("[TB] FAIL hold_pulses: pulses=%0d expected 1", pulses);
    else passCount++;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_flush();
    en_i = 1'b0; br_valid_i = 1'b1; br_cond_i = 8'h04; br_target_i = 8'h60;
    tick();
    br_valid_i = 1'b0;
    checkCount++;
    if (busy_o !== 1'b1 || pc_o !== 8'h60)
      $display("[TB] FAIL abort_pre: pc=%0h busy=%0b expected pc=60 busy=1", pc_o, busy_o);
    else passCount++;
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    checkCount++;
    if ({pc_o, taken_o, busy_o, br_ready_o} !== {8'h00, 3'b001})
      $display("[TB] FAIL abort_reset: pc=%0h taken=%0b busy=%0b ready=%0b expected pc=0 taken=0 busy=0 ready=1",
               pc_o, taken_o, busy_o, br_ready_o);
    else passCount++;
    #2;
    rst_ni = 1'b1;
    // Flags were cleared by reset (last written -2), so cond 1 (F==0) takes.
    br_valid_i = 1'b1; br_cond_i = 8'h01; br_target_i = 8'h24;
    tick();
    br_valid_i = 1'b0;
    checkCount++;
    if (pc_o !== 8'h24 || taken_o !== 1'b1)
      $display("[TB] FAIL abort_flags: pc=%0h taken=%0b expected pc=24 taken=1", pc_o, taken_o);
    else passCount++;
`ifdef COND_BRANCH_STATS_EN
    checkCount++;
    if (taken_count_o !== 16'd1 || nottaken_count_o !== 16'd0)
      $display("[TB] FAIL abort_stats: taken_count=%0d nottaken_count=%0d expected 1 and 0",
               taken_count_o, nottaken_count_o);
    else passCount++;
`endif
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_increment();
    test_wrap();
    test_forward_branch();
    test_cond_codes();
    test_flush_ignore();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cond_branch_seq.md
Name: cond_branch_seq

Overview:
- Program-counter sequencer on the consuming side of the condition interface.
- Holds an 8-bit flags value written by the ALU and evaluates branch condition codes against it, using the same 8-code condition encoding as the condition evaluator.
- Steers the PC: increments by STEP or loads the branch target, then inserts a fixed pipeline-flush bubble after every taken branch.
- Sits between instruction decode (branch requests) and instruction fetch (pc).

Parameters:
- PC_WIDTH, 8, width of pc and br_target.
- STEP, 4, PC increment per advancing cycle (instruction size in bytes).
- FLUSH_CYCLES, 2, bubble cycles after a taken branch; 0 disables the FLUSH state.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  advance enable; pc increments only when 1 and no taken branch.
- flag_valid  in  1  write flag_value into the flags register this cycle.
- flag_value  in  8  ALU result, two's-complement signed.
- br_valid  in  1  branch request present.
- br_cond  in  8  condition code; bits[2:0] used, bits[7:3] ignored.
- br_target  in  PC_WIDTH  destination address.
- br_ready  out  1  branch request can be accepted this cycle.
- pc  out  PC_WIDTH  current fetch address.
- taken  out  1  one-cycle pulse, registered, for each accepted taken branch.
- busy  out  1  high while in FLUSH.

Behaviour:
- Reset (rst=0, asynchronous): pc=0, flags=0, taken=0, busy=0, state=RUN, flush counter=0. br_ready=1 on the first cycle after rst deasserts.
- br_ready is combinational: br_ready = (state==RUN). Accept = br_valid & br_ready.
- Effective flags: flag_value when flag_valid=1 in the same cycle (forwarding), otherwise the flags register. The flags register updates on every edge where flag_valid=1, in any state.
- Conditions on effective flags F (signed):
  - 0 never; 1 F==0; 2 F<0; 3 F<=0
  - 4 always; 5 F!=0; 6 F>=0; 7 F>0
- RUN state, per cycle:
  - Accept with condition true: pc<=br_target and taken<=1 next cycle. If FLUSH_CYCLES>0, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN. A taken branch loads the target even when en=0.
  - Accept with condition false: treated as no branch; pc<=pc+STEP if en=1, else pc holds; taken<=0.
  - No accept: pc<=pc+STEP if en=1, else pc holds.
- FLUSH state: pc holds, busy=1, br_ready=0, br_valid ignored. The counter decrements each cycle; at counter==0 go to RUN on the next edge. FLUSH lasts exactly FLUSH_CYCLES cycles.
- The registered taken output is 0 in every cycle that does not immediately follow a taken accept.
- PC arithmetic wraps modulo 2^PC_WIDTH, with no overflow flag. br_target is used as-is.
- Reset asserted mid-FLUSH aborts the flush immediately: all state returns to reset values.
- Latency:
  - Branch decision to new pc visible: 1 cycle.
  - Flags write to use by a later branch: 0 cycles (forwarded).

Optional Feature:
- Macro: COND_BRANCH_STATS_EN.
- With it defined:
  - Extra output port taken_count [15:0]: counts accepted taken branches, saturates at 16'hFFFF, reset value 0.
  - Extra output port nottaken_count [15:0]: counts accepted not-taken branches, same saturation and reset.
- Without it: neither port nor either counter exists, and all other behaviour is identical.

Test Plan:
- Reset then en=1 for 5 cycles -> pc sequence 0,4,8,12,16,20; taken=0; br_ready=1 throughout.
- PC_WIDTH=8, pc=252, en=1 -> next pc=0 (wrap); busy stays 0.
- flag_valid=1 with flag_value=8'h00 and, in the same cycle, br_valid=1, br_cond=1, br_target=8'h40 -> pc=8'h40 next cycle, taken=1 for one cycle, busy=1 and br_ready=0 for 2 cycles, pc held at 8'h40 until en advances it to 8'h44.
- flags=8'hFE (−2), br_cond codes 2,3,5 taken and 1,6,7 not taken, target 8'h80 -> pc=8'h80 only for taken codes; not-taken codes give pc+4 with taken=0. br_cond=8'hF8 behaves as code 0 (never).
- br_valid held high during FLUSH with br_cond=4 -> ignored. Accepted only on the first RUN cycle; exactly one additional taken pulse.
- rst=0 asynchronously during the second FLUSH cycle -> pc=0, busy=0, taken=0 immediately. With COND_BRANCH_STATS_EN, counters read 0 and increment to 1 after the next taken branch.
